// File: rtl/elliptic_curve_structs.sv
// Shared types for the scalar-multiplication controller: affine point record,
// controller state encoding and curve parameters (NIST P-256 field modulus).
package elliptic_curve_structs;

    localparam int COORD_W = 256;
    localparam logic [COORD_W-1:0] CURVE_P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               inf;
    } point_t;

    localparam point_t INF_POINT = '{x: '0, y: '0, inf: 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DBL_LOAD,
        DBL_WAIT,
        ADD_LOAD,
        ADD_WAIT,
        NEXT,
        FIN
    } sm_state_t;

    // -P in affine form: y is negated modulo the field prime.
    function automatic point_t point_neg(input point_t p);
        point_t n;
        n   = p;
        n.y = (p.y == '0) ? '0 : CURVE_P - p.y;
        return n;
    endfunction

endpackage

// File: rtl/msb_detect.sv
// KW-bit priority encoder: index of the highest set bit of k, plus an all-zero flag.
module msb_detect #(
    parameter int KW = 256,
    parameter int IW = (KW > 1) ? $clog2(KW) : 1
) (
    input  logic [KW-1:0] k,
    output logic [IW-1:0] idx,
    output logic          zero
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < KW; i++) begin
            if (k[i]) idx = IW'(i);
        end
    end

    assign zero = ~|k;

endmodule

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer driving external point-double and
// point-add units. Define SCALAR_MULT_CT_EN for the fixed-schedule (constant-time) variant.
module scalar_mult_ctrl
    import elliptic_curve_structs::*;
#(
    parameter int KW = 256
) (
    input  logic           clk,
    input  logic           Reset,
    input  logic           start,
    input  logic [KW-1:0]  k,
    input  logic [255:0]   Px,
    input  logic [255:0]   Py,
    output logic           busy,
    output logic           done,
    output logic [255:0]   Rx,
    output logic [255:0]   Ry,
    output logic           Rinf,
    output logic           dbl_rst,
    output logic [255:0]   dbl_x,
    output logic [255:0]   dbl_y,
    input  logic           dbl_done,
    input  logic [255:0]   dbl_rx,
    input  logic [255:0]   dbl_ry,
    output logic           add_rst,
    output logic [255:0]   add_x1,
    output logic [255:0]   add_y1,
    output logic [255:0]   add_x2,
    output logic [255:0]   add_y2,
    input  logic           add_done,
    input  logic [255:0]   add_rx,
    input  logic [255:0]   add_ry
);

    localparam int IW = (KW > 1) ? $clog2(KW) : 1;

`ifdef SCALAR_MULT_CT_EN
    localparam bit CT_EN = 1'b1;
`else
    localparam bit CT_EN = 1'b0;
`endif

    sm_state_t      state_reg;
    logic [KW-1:0]  k_reg;
    point_t         p_reg;
    point_t         r_reg;
    logic [IW-1:0]  idx_reg;
    logic           ld_cnt_reg;
    logic           first_reg;
    logic           dbl_for_add_reg;
    logic           keep_reg;
    logic           busy_reg, done_reg, rinf_reg;
    logic [255:0]   rx_reg, ry_reg;
    logic           dbl_rst_reg, add_rst_reg;
    logic [255:0]   dbl_x_reg, dbl_y_reg;
    logic [255:0]   add_x1_reg, add_y1_reg, add_x2_reg, add_y2_reg;

    logic [IW-1:0]  msb_idx;
    logic           k_zero;
    logic           cur_bit;
    logic           r_is_p, r_is_neg, add_issue;

    msb_detect #(.KW(KW), .IW(IW)) u_msb_detect (
        .k    (k_reg),
        .idx  (msb_idx),
        .zero (k_zero)
    );

    assign cur_bit  = k_reg[idx_reg];
    assign r_is_p   = !r_reg.inf && (r_reg.x == p_reg.x) && (r_reg.y == p_reg.y);
    assign r_is_neg = !r_reg.inf && (r_reg.x == p_reg.x) && (r_reg.y != p_reg.y);
    // The fixed schedule still spends an addition slot on the special cases.
    assign add_issue = CT_EN || !(r_reg.inf || r_is_neg);

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_reg       <= IDLE;
            k_reg           <= '0;
            p_reg           <= '0;
            r_reg           <= '0;
            idx_reg         <= '0;
            ld_cnt_reg      <= 1'b0;
            first_reg       <= 1'b0;
            dbl_for_add_reg <= 1'b0;
            keep_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            rinf_reg        <= 1'b0;
            rx_reg          <= '0;
            ry_reg          <= '0;
            dbl_rst_reg     <= 1'b1;
            add_rst_reg     <= 1'b1;
            dbl_x_reg       <= '0;
            dbl_y_reg       <= '0;
            add_x1_reg      <= '0;
            add_y1_reg      <= '0;
            add_x2_reg      <= '0;
            add_y2_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        k_reg     <= k;
                        p_reg     <= '{x: Px, y: Py, inf: 1'b0};
                        busy_reg  <= 1'b1;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (CT_EN) begin
                        r_reg     <= INF_POINT;
                        idx_reg   <= IW'(KW - 1);
                        state_reg <= DBL_LOAD;
                    end else if (k_zero) begin
                        r_reg     <= INF_POINT;
                        state_reg <= FIN;
                    end else begin
                        r_reg     <= p_reg;
                        idx_reg   <= msb_idx;
                        state_reg <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_reg == '0) begin
                        state_reg <= FIN;
                    end else begin
                        idx_reg   <= idx_reg - IW'(1);
                        state_reg <= DBL_LOAD;
                    end
                end
                DBL_LOAD: begin
                    if (!ld_cnt_reg) begin
                        if (!CT_EN && r_reg.inf && !dbl_for_add_reg) begin
                            // Doubling infinity is infinity: no unit operation needed.
                            state_reg <= cur_bit ? ADD_LOAD : NEXT;
                        end else begin
                            dbl_x_reg  <= dbl_for_add_reg ? p_reg.x : r_reg.x;
                            dbl_y_reg  <= dbl_for_add_reg ? p_reg.y : r_reg.y;
                            ld_cnt_reg <= 1'b1;
                        end
                    end else begin
                        ld_cnt_reg  <= 1'b0;
                        dbl_rst_reg <= 1'b0;
                        first_reg   <= 1'b1;
                        state_reg   <= DBL_WAIT;
                    end
                end
                DBL_WAIT: begin
                    first_reg <= 1'b0;
                    if (!first_reg && dbl_done) begin
                        dbl_rst_reg <= 1'b1;
                        if (dbl_for_add_reg) begin
                            if (keep_reg) r_reg <= '{x: dbl_rx, y: dbl_ry, inf: 1'b0};
                            dbl_for_add_reg <= 1'b0;
                            state_reg       <= NEXT;
                        end else begin
                            if (!r_reg.inf) r_reg <= '{x: dbl_rx, y: dbl_ry, inf: 1'b0};
                            state_reg <= (CT_EN || cur_bit) ? ADD_LOAD : NEXT;
                        end
                    end
                end
                ADD_LOAD: begin
                    if (!ld_cnt_reg) begin
                        if (r_is_p) begin
                            // R == P cannot go through the adder; reroute to a doubling of P.
                            dbl_for_add_reg <= 1'b1;
                            keep_reg        <= cur_bit;
                            state_reg       <= DBL_LOAD;
                        end else begin
                            if (r_reg.inf && cur_bit) r_reg <= p_reg;
                            if (r_is_neg && cur_bit)  r_reg <= INF_POINT;
                            if (add_issue) begin
                                add_x1_reg <= r_reg.x;
                                add_y1_reg <= r_reg.y;
                                add_x2_reg <= p_reg.x;
                                add_y2_reg <= p_reg.y;
                                keep_reg   <= cur_bit && !r_reg.inf && !r_is_neg;
                                ld_cnt_reg <= 1'b1;
                            end else begin
                                state_reg <= NEXT;
                            end
                        end
                    end else begin
                        ld_cnt_reg  <= 1'b0;
                        add_rst_reg <= 1'b0;
                        first_reg   <= 1'b1;
                        state_reg   <= ADD_WAIT;
                    end
                end
                ADD_WAIT: begin
                    first_reg <= 1'b0;
                    if (!first_reg && add_done) begin
                        add_rst_reg <= 1'b1;
                        if (keep_reg) r_reg <= '{x: add_rx, y: add_ry, inf: 1'b0};
                        state_reg <= NEXT;
                    end
                end
                FIN: begin
                    rx_reg    <= r_reg.x;
                    ry_reg    <= r_reg.y;
                    rinf_reg  <= r_reg.inf;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign Rx      = rx_reg;
    assign Ry      = ry_reg;
    assign Rinf    = rinf_reg;
    assign dbl_rst = dbl_rst_reg;
    assign dbl_x   = dbl_x_reg;
    assign dbl_y   = dbl_y_reg;
    assign add_rst = add_rst_reg;
    assign add_x1  = add_x1_reg;
    assign add_y1  = add_y1_reg;
    assign add_x2  = add_x2_reg;
    assign add_y2  = add_y2_reg;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl with 10-cycle mock double/add units whose
// results are a simple linear model (2*(x,y) and sum) or special-case variants.
module tb_scalar_mult_ctrl;
    import elliptic_curve_structs::*;

`ifdef SCALAR_MULT_CT_EN
    localparam int TKW = 8;
`else
    localparam int TKW = 256;
`endif
    localparam int LAT    = 10;
    localparam int BUDGET = 3000;

    logic            clk, Reset, start;
    logic [TKW-1:0]  k;
    logic [255:0]    Px, Py;
    logic            busy, done, Rinf;
    logic [255:0]    Rx, Ry;
    logic            dbl_rst, dbl_done, add_rst, add_done;
    logic [255:0]    dbl_x, dbl_y, dbl_rx, dbl_ry;
    logic [255:0]    add_x1, add_y1, add_x2, add_y2, add_rx, add_ry;

    scalar_mult_ctrl #(.KW(TKW)) dut (
        .clk(clk), .Reset(Reset), .start(start), .k(k), .Px(Px), .Py(Py),
        .busy(busy), .done(done), .Rx(Rx), .Ry(Ry), .Rinf(Rinf),
        .dbl_rst(dbl_rst), .dbl_x(dbl_x), .dbl_y(dbl_y), .dbl_done(dbl_done),
        .dbl_rx(dbl_rx), .dbl_ry(dbl_ry),
        .add_rst(add_rst), .add_x1(add_x1), .add_y1(add_y1), .add_x2(add_x2),
        .add_y2(add_y2), .add_done(add_done), .add_rx(add_rx), .add_ry(add_ry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mock units. mode 0: linear; mode 1: double returns -P; mode 2: double returns its input.
    int   mode = 0;
    logic stale_dbl = 1'b0;
    int   dcnt = 0, acnt = 0;
    logic dbl_done_m = 1'b0, add_done_m = 1'b0;
    assign dbl_done = dbl_done_m | stale_dbl;
    assign add_done = add_done_m;

    always @(posedge clk) begin
        if (dbl_rst) begin
            dcnt <= 0; dbl_done_m <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
            dbl_done_m <= (dcnt == LAT - 1);
            if (dcnt == LAT - 1) begin
                case (mode)
                    1:       begin dbl_rx <= dbl_x; dbl_ry <= CURVE_P - dbl_y; end
                    2:       begin dbl_rx <= dbl_x; dbl_ry <= dbl_y; end
                    default: begin dbl_rx <= dbl_x << 1; dbl_ry <= dbl_y << 1; end
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (add_rst) begin
            acnt <= 0; add_done_m <= 1'b0;
        end else begin
            acnt <= acnt + 1;
            add_done_m <= (acnt == LAT - 1);
            if (acnt == LAT - 1) begin
                add_rx <= add_x1 + add_x2;
                add_ry <= add_y1 + add_y2;
            end
        end
    end

    // Operation monitor: a unit operation starts when its hold-reset falls.
    int    dbl_issues = 0, add_issues = 0, done_pulses = 0;
    string ops = "";
    logic  dbl_rst_q = 1'b1, add_rst_q = 1'b1;
    always @(negedge clk) begin
        if (dbl_rst_q && !dbl_rst) begin dbl_issues++; ops = {ops, "D"}; end
        if (add_rst_q && !add_rst) begin add_issues++; ops = {ops, "A"}; end
        if (done) done_pulses++;
        dbl_rst_q = dbl_rst;
        add_rst_q = add_rst;
    end

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    int    last_cyc, last_nd, last_na, last_np;
    string last_ops;

    task automatic run_mult(input logic [TKW-1:0] kk, input logic [255:0] x, input logic [255:0] y);
        int d0, a0, p0, o0;
        d0 = dbl_issues; a0 = add_issues; p0 = done_pulses; o0 = ops.len();
        @(negedge clk);
        k = kk; Px = x; Py = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        last_cyc = 1;
        while (!done && last_cyc < BUDGET) begin
            @(negedge clk);
            last_cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: no done after %0d cycles, required done=1", last_cyc);
        end
        repeat (2) @(negedge clk);
        last_nd  = dbl_issues - d0;
        last_na  = add_issues - a0;
        last_np  = done_pulses - p0;
        last_ops = ops.substr(o0, ops.len() - 1);
    endtask

    typedef struct {
        logic [255:0] kv;
        logic [255:0] px, py;
        int           md;
        logic [255:0] rx, ry;
        logic         inf;
        int           nd, na;
    } vec_t;

    vec_t tv [10];

    initial begin
        Reset = 1'b0; start = 1'b0; k = '0; Px = '0; Py = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_rinf", 256'(Rinf), 256'(0));
        check("rst_rx", Rx, 256'(0));
        check("rst_dbl_rst", 256'(dbl_rst), 256'(1));
        check("rst_add_rst", 256'(add_rst), 256'(1));
        Reset = 1'b1;
        @(negedge clk);

`ifndef SCALAR_MULT_CT_EN
        //        k       Px      Py      md  Rx       Ry       inf nd na
        tv[0] = '{256'h0,  256'd9, 256'd9,  0, 256'd0,   256'd0,   1'b1, 0, 0};
        tv[1] = '{256'h1,  256'd5, 256'd7,  0, 256'd5,   256'd7,   1'b0, 0, 0};
        tv[2] = '{256'h5,  256'd3, 256'd11, 0, 256'd15,  256'd55,  1'b0, 2, 1};
        tv[3] = '{256'h6,  256'd2, 256'd3,  0, 256'd12,  256'd18,  1'b0, 2, 1};
        tv[4] = '{256'hFF, 256'd1, 256'd2,  0, 256'd255, 256'd510, 1'b0, 7, 7};
        tv[5] = '{256'h80, 256'd4, 256'd1,  0, 256'd512, 256'd128, 1'b0, 7, 0};
        // Double yields -P, so the following addition collapses to infinity.
        tv[6] = '{256'h3,  256'd5, 256'd7,  1, 256'd0,   256'd0,   1'b1, 1, 0};
        tv[7] = '{256'h6,  256'd5, 256'd7,  1, 256'd0,   256'd0,   1'b1, 1, 0};
        tv[8] = '{256'h7,  256'd5, 256'd7,  1, 256'd5,   256'd7,   1'b0, 1, 0};
        // Double yields P, so the addition R==P becomes a second doubling.
        tv[9] = '{256'h3,  256'd5, 256'd7,  2, 256'd5,   256'd7,   1'b0, 2, 0};

        for (int i = 0; i < 10; i++) begin
            mode = tv[i].md;
            run_mult(TKW'(tv[i].kv), tv[i].px, tv[i].py);
            check($sformatf("v%0d_rx", i), Rx, tv[i].rx);
            check($sformatf("v%0d_ry", i), Ry, tv[i].ry);
            check($sformatf("v%0d_rinf", i), 256'(Rinf), 256'(tv[i].inf));
            check($sformatf("v%0d_ndbl", i), 256'(last_nd), 256'(tv[i].nd));
            check($sformatf("v%0d_nadd", i), 256'(last_na), 256'(tv[i].na));
            check($sformatf("v%0d_pulses", i), 256'(last_np), 256'(1));
            if (tv[i].kv == 256'h0)
                check("k0_latency_le4", 256'(last_cyc <= 4), 256'(1));
            $display("vec %0d k=%0h mode=%0d -> Rx=%0h Ry=%0h Rinf=%0b dbl=%0d add=%0d cyc=%0d",
                     i, tv[i].kv, tv[i].md, Rx, Ry, Rinf, last_nd, last_na, last_cyc);
        end

        // start while busy must not disturb the running k=5 job
        begin
            int o0, p0, n;
            mode = 0;
            o0 = ops.len(); p0 = done_pulses;
            @(negedge clk);
            k = TKW'(5); Px = 256'd3; Py = 256'd11; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (6) @(negedge clk);
            k = TKW'(1); Px = 256'd8; Py = 256'd8; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (!done && n < BUDGET) begin @(negedge clk); n++; end
            repeat (2) @(negedge clk);
            check("busy_start_rx", Rx, 256'd15);
            check("busy_start_ry", Ry, 256'd55);
            check_str("busy_start_order", ops.substr(o0, ops.len() - 1), "DDA");
            check("busy_start_pulses", 256'(done_pulses - p0), 256'(1));
            $display("busy-start k=5 -> Rx=%0h Ry=%0h ops=%s", Rx, Ry, ops.substr(o0, ops.len() - 1));
        end
`endif

        // Reset while a doubling is in flight, stale dbl_done, then a clean k=3 run
        begin
            int n, p0;
            mode = 0;
            @(negedge clk);
            k = TKW'(5); Px = 256'd3; Py = 256'd11; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (dbl_rst && n < 50) begin @(negedge clk); n++; end
            check("midrst_reached_wait", 256'(dbl_rst), 256'(0));
            Reset = 1'b0;
            @(negedge clk);
            Reset = 1'b1;
            check("midrst_busy", 256'(busy), 256'(0));
            check("midrst_dbl_rst", 256'(dbl_rst), 256'(1));
            check("midrst_add_rst", 256'(add_rst), 256'(1));
            check("midrst_dbl_x", dbl_x, 256'(0));
            check("midrst_rx", Rx, 256'(0));
            p0 = done_pulses;
            stale_dbl = 1'b1;
            repeat (3) @(negedge clk);
            stale_dbl = 1'b0;
            check("stale_no_done", 256'(done_pulses - p0), 256'(0));
            check("stale_busy", 256'(busy), 256'(0));
            run_mult(TKW'(3), 256'd3, 256'd11);
            check("restart_rx", Rx, 256'd9);
            check("restart_ry", Ry, 256'd33);
`ifdef SCALAR_MULT_CT_EN
            check("restart_ndbl", 256'(last_nd), 256'(TKW));
            check("restart_nadd", 256'(last_na), 256'(TKW));
`else
            check("restart_ndbl", 256'(last_nd), 256'(1));
            check("restart_nadd", 256'(last_na), 256'(1));
`endif
            $display("restart k=3 -> Rx=%0h Ry=%0h ops=%s", Rx, Ry, last_ops);
        end

`ifdef SCALAR_MULT_CT_EN
        begin
            int cyc01;
            mode = 0;
            run_mult(TKW'(8'h01), 256'd1, 256'd2);
            cyc01 = last_cyc;
            check("ct01_rx", Rx, 256'd1);
            check("ct01_ry", Ry, 256'd2);
            check("ct01_ndbl", 256'(last_nd), 256'(8));
            check("ct01_nadd", 256'(last_na), 256'(8));
            $display("ct k=01 -> Rx=%0h Ry=%0h cyc=%0d", Rx, Ry, last_cyc);
            run_mult(TKW'(8'hFF), 256'd1, 256'd2);
            check("ctff_rx", Rx, 256'd255);
            check("ctff_ry", Ry, 256'd510);
            check("ctff_ndbl", 256'(last_nd), 256'(8));
            check("ctff_nadd", 256'(last_na), 256'(8));
            check("ct_same_cycles", 256'(last_cyc), 256'(cyc01));
            $display("ct k=ff -> Rx=%0h Ry=%0h cyc=%0d", Rx, Ry, last_cyc);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
